// File: rtl/trap_ctrl_if.sv
// Commit-stage trap/return bus: commit instruction, interrupt levels, CSR reads, CSR writes, redirect.
// Latency and backpressure belong to the attached modules; trap_busy tells the commit stage to hold.
interface trap_ctrl_if;
    // commit stage
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [5:0]  commit_exc;
    logic [31:0] commit_tval;
    logic        commit_mret;
    // interrupt levels
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_soft;
    // CSR file read side
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [29:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic [31:0] mepc_value;
    // pipeline control and redirect
    logic        trap_flush;
    logic        trap_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    // CSR file hardware write ports
    logic [31:0] mepc_o;
    logic        mepc_wen;
    logic        mcause_int_o;
    logic        mcause_int_wen;
    logic [30:0] mcause_code_o;
    logic        mcause_code_wen;
    logic [31:0] mtval_o;
    logic        mtval_wen;
    logic        mie_o;
    logic        mie_wen;
    logic        mpie_o;
    logic        mpie_wen;
    logic [1:0]  mpp_o;
    logic        mpp_wen;

    modport master (
        output commit_valid, commit_pc, commit_exc, commit_tval, commit_mret,
        output irq_ext, irq_timer, irq_soft,
        output mstatus_mie, mstatus_mpie, mtvec_base, mtvec_mode, mepc_value,
        input  trap_flush, trap_busy, redirect_valid, redirect_pc,
        input  mepc_o, mepc_wen, mcause_int_o, mcause_int_wen, mcause_code_o, mcause_code_wen,
        input  mtval_o, mtval_wen, mie_o, mie_wen, mpie_o, mpie_wen, mpp_o, mpp_wen
    );

    modport slave (
        input  commit_valid, commit_pc, commit_exc, commit_tval, commit_mret,
        input  irq_ext, irq_timer, irq_soft,
        input  mstatus_mie, mstatus_mpie, mtvec_base, mtvec_mode, mepc_value,
        output trap_flush, trap_busy, redirect_valid, redirect_pc,
        output mepc_o, mepc_wen, mcause_int_o, mcause_int_wen, mcause_code_o, mcause_code_wen,
        output mtval_o, mtval_wen, mie_o, mie_wen, mpie_o, mpie_wen, mpp_o, mpp_wen
    );
endinterface

// File: rtl/trap_ctrl.sv
// Commit-stage trap/mret sequencer: accept in IDLE (flush same cycle), CSR writes + redirect one cycle later.
// One event in flight; trap_busy holds the commit stage during ENTER/RETURN, so nothing is dropped.
module trap_ctrl #(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_RETURN
    } state_e;

    typedef struct packed {
        logic [31:0] mepc;
        logic        mepc_wen;
        logic        mcause_int;
        logic        mcause_int_wen;
        logic [30:0] mcause_code;
        logic        mcause_code_wen;
        logic [31:0] mtval;
        logic        mtval_wen;
        logic        mie;
        logic        mie_wen;
        logic        mpie;
        logic        mpie_wen;
        logic [1:0]  mpp;
        logic        mpp_wen;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
    } csr_wr_t;

    state_e                       state_q, state_d;
    csr_wr_t                      out_q, out_d;
    logic [IRQ_SYNC_STAGES-1:0]   irq_sync_q;

    logic       irq_ext_sync;
    logic       irq_pend;
    logic [4:0] irq_code;
    logic       exc_any;
    logic [4:0] exc_code;
    logic       exc_has_tval;
    logic       flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_sync_q <= '0;
        end else begin
            irq_sync_q <= {irq_sync_q[IRQ_SYNC_STAGES-2:0], bus.irq_ext};
        end
    end

    assign irq_ext_sync = irq_sync_q[IRQ_SYNC_STAGES-1];
    assign irq_pend     = bus.mstatus_mie & (irq_ext_sync | bus.irq_soft | bus.irq_timer);
    assign exc_any      = |bus.commit_exc;

    always_comb begin
        irq_code = 5'd7;
        if (irq_ext_sync) begin
            irq_code = 5'd11;
        end else if (bus.irq_soft) begin
            irq_code = 5'd3;
        end
    end

    // Only misaligned and illegal causes carry a meaningful tval.
    always_comb begin
        exc_code     = 5'd0;
        exc_has_tval = 1'b0;
        if (bus.commit_exc[0]) begin
            exc_code     = 5'd0;
            exc_has_tval = 1'b1;
        end else if (bus.commit_exc[1]) begin
            exc_code     = 5'd2;
            exc_has_tval = 1'b1;
        end else if (bus.commit_exc[2]) begin
            exc_code     = 5'd3;
        end else if (bus.commit_exc[3]) begin
            exc_code     = 5'd11;
        end else if (bus.commit_exc[4]) begin
            exc_code     = 5'd4;
            exc_has_tval = 1'b1;
        end else if (bus.commit_exc[5]) begin
            exc_code     = 5'd6;
            exc_has_tval = 1'b1;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        out_d   = '0;
        flush   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.commit_valid && !rst) begin
                    if (irq_pend || exc_any) begin
                        flush                 = 1'b1;
                        state_d               = S_ENTER;
                        out_d.mepc            = bus.commit_pc;
                        out_d.mepc_wen        = 1'b1;
                        out_d.mcause_int      = irq_pend;
                        out_d.mcause_int_wen  = 1'b1;
                        out_d.mcause_code     = {26'd0, irq_pend ? irq_code : exc_code};
                        out_d.mcause_code_wen = 1'b1;
                        out_d.mtval           = (!irq_pend && exc_has_tval) ? bus.commit_tval : 32'd0;
                        out_d.mtval_wen       = 1'b1;
                        out_d.mie             = 1'b0;
                        out_d.mie_wen         = 1'b1;
                        out_d.mpie            = bus.mstatus_mie;
                        out_d.mpie_wen        = 1'b1;
                        out_d.mpp             = 2'b11;
                        out_d.mpp_wen         = 1'b1;
                        out_d.redirect_valid  = 1'b1;
                        // Vectoring applies to interrupts in mode 1 only; modes 2/3 act as direct.
                        out_d.redirect_pc     = {bus.mtvec_base, 2'b00}
                                              + ((irq_pend && bus.mtvec_mode == 2'd1)
                                                 ? {25'd0, irq_code, 2'b00} : 32'd0);
                    end else if (bus.commit_mret) begin
                        flush                 = 1'b1;
                        state_d               = S_RETURN;
                        out_d.mie             = bus.mstatus_mpie;
                        out_d.mie_wen         = 1'b1;
                        out_d.mpie            = 1'b1;
                        out_d.mpie_wen        = 1'b1;
                        out_d.mpp             = 2'b11;
                        out_d.mpp_wen         = 1'b1;
                        out_d.redirect_valid  = 1'b1;
                        out_d.redirect_pc     = bus.mepc_value;
                    end
                end
            end
            S_ENTER, S_RETURN: state_d = S_IDLE;
            default:           state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign bus.trap_flush      = flush;
    assign bus.trap_busy       = (state_q != S_IDLE);
    assign bus.redirect_valid  = out_q.redirect_valid;
    assign bus.redirect_pc     = out_q.redirect_pc;
    assign bus.mepc_o          = out_q.mepc;
    assign bus.mepc_wen        = out_q.mepc_wen;
    assign bus.mcause_int_o    = out_q.mcause_int;
    assign bus.mcause_int_wen  = out_q.mcause_int_wen;
    assign bus.mcause_code_o   = out_q.mcause_code;
    assign bus.mcause_code_wen = out_q.mcause_code_wen;
    assign bus.mtval_o         = out_q.mtval;
    assign bus.mtval_wen       = out_q.mtval_wen;
    assign bus.mie_o           = out_q.mie;
    assign bus.mie_wen         = out_q.mie_wen;
    assign bus.mpie_o          = out_q.mpie;
    assign bus.mpie_wen        = out_q.mpie_wen;
    assign bus.mpp_o           = out_q.mpp;
    assign bus.mpp_wen         = out_q.mpp_wen;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: expected CSR writes/redirects queued at acceptance, compared when redirect fires.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if bus ();

    trap_ctrl #(.IRQ_SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          ret;
        logic [31:0] mepc;
        logic        intr;
        logic [30:0] code;
        logic [31:0] mtval;
        logic        mie;
        logic        mpie;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.redirect_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_redirect", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("redir_pc", bus.redirect_pc, mon_e.rpc);
                chk("busy_out", bus.trap_busy, 1);
                chk("mepc_wen", bus.mepc_wen, !mon_e.ret);
                chk("int_wen",  bus.mcause_int_wen, !mon_e.ret);
                chk("code_wen", bus.mcause_code_wen, !mon_e.ret);
                chk("mtval_wen", bus.mtval_wen, !mon_e.ret);
                chk("mie_wen",  bus.mie_wen, 1);
                chk("mpie_wen", bus.mpie_wen, 1);
                chk("mpp_wen",  bus.mpp_wen, 1);
                chk("mie_o",    bus.mie_o, mon_e.mie);
                chk("mpie_o",   bus.mpie_o, mon_e.mpie);
                chk("mpp_o",    bus.mpp_o, 2'b11);
                if (!mon_e.ret) begin
                    chk("mepc_o",  bus.mepc_o, mon_e.mepc);
                    chk("int_o",   bus.mcause_int_o, mon_e.intr);
                    chk("code_o",  bus.mcause_code_o, mon_e.code);
                    chk("mtval_o", bus.mtval_o, mon_e.mtval);
                end
            end
        end
    end

    task automatic push_exp(input int kind, input logic [31:0] pc, input logic intr,
                            input logic [30:0] code, input logic [31:0] mtval, input logic [31:0] rpc);
        exp_t e;
        e.ret   = (kind == 2);
        e.mepc  = pc;
        e.intr  = intr;
        e.code  = code;
        e.mtval = mtval;
        e.mie   = (kind == 2) ? bus.mstatus_mpie : 1'b0;
        e.mpie  = (kind == 2) ? 1'b1 : bus.mstatus_mie;
        e.rpc   = rpc;
        sb.push_back(e);
    endtask

    // kind: 0 no event, 1 trap, 2 mret
    task automatic run_evt(input string tag, input logic [31:0] pc, input logic [5:0] exc,
                           input logic [31:0] tval, input logic mret, input int kind,
                           input logic intr, input logic [30:0] code, input logic [31:0] mtval,
                           input logic [31:0] rpc);
        @(posedge clk); #1;
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_exc   = exc;
        bus.commit_tval  = tval;
        bus.commit_mret  = mret;
        @(negedge clk);
        chk({tag, "_flush"}, bus.trap_flush, kind != 0);
        if (kind != 0) push_exp(kind, pc, intr, code, mtval, rpc);
        @(posedge clk); #1;
        bus.commit_valid = 1'b0;
        bus.commit_exc   = '0;
        bus.commit_mret  = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, bus.trap_busy, kind != 0);
        chk({tag, "_rvld"}, bus.redirect_valid, kind != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.commit_valid = 0; bus.commit_pc = 0; bus.commit_exc = 0; bus.commit_tval = 0;
        bus.commit_mret = 0; bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_soft = 0;
        bus.mstatus_mie = 1; bus.mstatus_mpie = 0; bus.mtvec_base = 30'h80; bus.mtvec_mode = 0;
        bus.mepc_value = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.trap_busy, 0);
        chk("rst_flush", bus.trap_flush, 0);
        chk("rst_rvld", bus.redirect_valid, 0);
        chk("rst_rpc", bus.redirect_pc, 0);
        chk("rst_wens", {bus.mepc_wen, bus.mcause_int_wen, bus.mcause_code_wen, bus.mtval_wen,
                         bus.mie_wen, bus.mpie_wen, bus.mpp_wen}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // exceptions, direct mode
        run_evt("illegal", 32'h100, 6'b000010, 32'hFFFF_FFFF, 0, 1, 0, 2, 32'hFFFF_FFFF, 32'h200);
        run_evt("ebk_ecall", 32'h104, 6'b001100, 32'hDEAD, 0, 1, 0, 3, 0, 32'h200);
        run_evt("ld_st_mis", 32'h108, 6'b110000, 32'h55, 0, 1, 0, 4, 32'h55, 32'h200);
        run_evt("st_mis", 32'h10C, 6'b100000, 32'h77, 0, 1, 0, 6, 32'h77, 32'h200);
        run_evt("if_mis", 32'h110, 6'b000011, 32'h13, 0, 1, 0, 0, 32'h13, 32'h200);
        run_evt("ecall", 32'h114, 6'b001000, 32'h99, 0, 1, 0, 11, 0, 32'h200);

        // interrupts, vectored mode
        bus.mtvec_mode = 2'd1;
        bus.irq_timer  = 1'b1;
        run_evt("timer_vec", 32'h118, 6'b0, 0, 0, 1, 1, 7, 0, 32'h21C);
        bus.mstatus_mie = 1'b0;
        run_evt("timer_masked", 32'h11C, 6'b0, 0, 0, 0, 0, 0, 0, 0);
        bus.mstatus_mie = 1'b1;
        bus.irq_soft = 1'b1;
        run_evt("soft_vec", 32'h120, 6'b0, 0, 0, 1, 1, 3, 0, 32'h20C);
        bus.irq_soft = 1'b0;
        bus.mtvec_mode = 2'd2;
        run_evt("timer_mode2", 32'h124, 6'b0, 0, 0, 1, 1, 7, 0, 32'h200);
        bus.irq_timer = 1'b0;
        bus.mtvec_mode = 2'd1;
        run_evt("exc_vec", 32'h128, 6'b001000, 0, 0, 1, 0, 11, 0, 32'h200);

        // ext + timer + illegal: interrupt wins, exception ignored
        bus.irq_ext = 1'b1;
        bus.irq_timer = 1'b1;
        idle(3);
        run_evt("ext_prio", 32'h130, 6'b000010, 32'hABCD, 0, 1, 1, 11, 0, 32'h22C);
        bus.irq_ext = 1'b0;
        bus.irq_timer = 1'b0;
        bus.mtvec_mode = 2'd0;
        idle(4);

        // irq_ext synchroniser latency
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h300; bus.irq_ext = 1'b1;
        @(negedge clk); chk("sync_t0", bus.trap_flush, 0);
        @(negedge clk); chk("sync_t1", bus.trap_flush, 0);
        @(negedge clk); chk("sync_t2", bus.trap_flush, 1);
        push_exp(1, 32'h300, 1, 11, 0, 32'h200);
        @(posedge clk); #1;
        bus.commit_valid = 1'b0; bus.irq_ext = 1'b0;
        @(negedge clk); chk("sync_rvld", bus.redirect_valid, 1);
        idle(4);

        // mret
        bus.mepc_value = 32'h1234; bus.mstatus_mpie = 1'b1;
        run_evt("mret", 32'h140, 6'b0, 0, 1, 2, 0, 0, 0, 32'h1234);
        bus.mstatus_mpie = 1'b0;
        run_evt("mret_mpie0", 32'h144, 6'b0, 0, 1, 2, 0, 0, 0, 32'h1234);
        run_evt("mret_ecall", 32'h148, 6'b001000, 0, 1, 1, 0, 11, 0, 32'h200);

        // commit_valid low: no event
        bus.commit_exc = 6'b000010; bus.commit_mret = 1'b1;
        @(negedge clk); chk("novalid_flush", bus.trap_flush, 0);
        @(posedge clk); #1;
        bus.commit_exc = 0; bus.commit_mret = 0;

        // reset during ENTER
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h150; bus.commit_exc = 6'b000010;
        bus.commit_tval = 32'h5;
        @(negedge clk); chk("rstenter_flush", bus.trap_flush, 1);
        push_exp(1, 32'h150, 0, 2, 32'h5, 32'h200);
        @(posedge clk); #1;
        bus.commit_valid = 1'b0; bus.commit_exc = 0; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstenter_busy", bus.trap_busy, 0);
        chk("rstenter_rvld", bus.redirect_valid, 0);
        chk("rstenter_wens", {bus.mepc_wen, bus.mcause_int_wen, bus.mcause_code_wen, bus.mtval_wen,
                              bus.mie_wen, bus.mpie_wen, bus.mpp_wen}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // back-to-back held exception
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h160; bus.commit_exc = 6'b000100;
        @(negedge clk); chk("b2b_n0", bus.trap_flush, 1);
        push_exp(1, 32'h160, 0, 3, 0, 32'h200);
        @(negedge clk);
        chk("b2b_n1_flush", bus.trap_flush, 0);
        chk("b2b_n1_busy", bus.trap_busy, 1);
        @(negedge clk); chk("b2b_n2", bus.trap_flush, 1);
        push_exp(1, 32'h160, 0, 3, 0, 32'h200);
        @(posedge clk); #1;
        bus.commit_valid = 1'b0; bus.commit_exc = 0;
        @(negedge clk); chk("b2b_rvld", bus.redirect_valid, 1);
        idle(3);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
